muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_unit.sv | 139 +++++++++++++
 tb/tb_muldiv_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide unit: operand width, funct3 operation codes and FSM states.
package muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: radix-2 shift-add multiply / restoring divide on magnitudes, sign fixed up afterwards.
// Latency BIT_WIDTH+2 cycles to done (1 cycle for divide-by-zero/overflow); start is ignored unless IDLE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int BIT_WIDTH = XLEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           funct3,
  input  logic [BIT_WIDTH-1:0] rs1_data,
  input  logic [BIT_WIDTH-1:0] rs2_data,
  output logic                 busy,
  output logic                 done,
  output logic [BIT_WIDTH-1:0] result
);

  localparam int W  = BIT_WIDTH;
  localparam int CW = $clog2(BIT_WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(BIT_WIDTH - 1);
  localparam logic [W-1:0]  MIN_NEG   = {1'b1, {(W-1){1'b0}}};

  function automatic logic rs1_signed(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic rs2_signed(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

  // The most negative value negates to itself, which is exactly its unsigned magnitude.
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  muldiv_state_e   state_q;
  muldiv_op_e      op_q;
  logic            neg_a_q, neg_b_q;
  logic [W-1:0]    b_mag_q;
  logic [2*W-1:0]  acc_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q, done_q;
  logic [W-1:0]    result_q;

  muldiv_op_e      op_in;
  logic            in_neg_a, in_neg_b, in_div_zero, in_overflow;

  assign op_in       = muldiv_op_e'(funct3);
  assign in_neg_a    = rs1_signed(op_in) & rs1_data[W-1];
  assign in_neg_b    = rs2_signed(op_in) & rs2_data[W-1];
  assign in_div_zero = funct3[2] && (rs2_data == '0);
  assign in_overflow = (op_in == OP_DIV || op_in == OP_REM) &&
                       (rs1_data == MIN_NEG) && (rs2_data == '1);

  logic [W:0]     mul_sum, div_sh, div_diff;
  logic [2*W-1:0] mul_next, div_next, prod_signed, acc_d;
  logic [W-1:0]   quo, rem, result_d;

  // acc_q holds {high, low} product for multiplies and {remainder, quotient} for divides.
  always_comb begin
    mul_sum     = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);
    mul_next    = {mul_sum, acc_q[W-1:1]};
    div_sh      = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff    = div_sh - {1'b0, b_mag_q};
    div_next    = div_diff[W] ? {div_sh[W-1:0],   acc_q[W-2:0], 1'b0}
                              : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
    acc_d       = op_q[2] ? div_next : mul_next;
    prod_signed = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo         = acc_q[W-1:0];
    rem         = acc_q[2*W-1:W];
    case (op_q)
      OP_MUL:                        result_d = prod_signed[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result_d = prod_signed[2*W-1:W];
      OP_DIV, OP_DIVU:               result_d = (neg_a_q ^ neg_b_q) ? -quo : quo;
      default:                       result_d = neg_a_q ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_mag_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q    <= op_in;
            neg_a_q <= in_neg_a;
            neg_b_q <= in_neg_b;
            b_mag_q <= magnitude(rs2_data, in_neg_b);
            acc_q   <= {{W{1'b0}}, magnitude(rs1_data, in_neg_a)};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            if (in_div_zero || in_overflow) begin
              // funct3[1] separates remainder ops from quotient ops.
              if (in_div_zero) result_q <= funct3[1] ? rs1_data : '1;
              else             result_q <= funct3[1] ? '0 : MIN_NEG;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) state_q <= ST_FIX;
        end
        ST_FIX: begin
          result_q <= result_d;
          done_q   <= 1'b1;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit against a plain-arithmetic RV32M reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        busy, done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.BIT_WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 0) ||
           ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // poke > 0: pulse start again at that cycle; poke < 0: pulse start during the done cycle.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int poke);
    logic [31:0] exp;
    int exp_lat, lat, busy_pre, extra;
    bit seen;
    exp      = ref_model(op, a, b);
    exp_lat  = is_special(op, a, b) ? 1 : 34;
    busy_pre = 0;
    extra    = 0;
    seen     = 0;
    @(negedge clk);
    start = 1'b1; funct3 = op; rs1_data = a; rs2_data = b;
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
    lat = 1;
    while (!seen && lat <= 100) begin
      if (done === 1'b1) seen = 1;
      else begin
        if (busy === 1'b1) busy_pre++;
        if (lat == poke) begin
          start = 1'b1; funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
        end
        @(posedge clk); #1;
        start = 1'b0;
        lat++;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, result, exp);
    check({tag, " busy_before_done"}, 64'(busy_pre), 64'(exp_lat - 1));
    check({tag, " busy_in_done"}, busy, 1'b1);
    if (poke < 0) begin
      start = 1'b1; funct3 = 3'd0; rs1_data = 32'd1; rs2_data = 32'd1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " done_one_pulse"}, done, 1'b0);
    check({tag, " idle_after"}, busy, 1'b0);
    if (poke != 0) begin
      repeat (40) begin
        @(posedge clk); #1;
        if (done === 1'b1 || busy === 1'b1) extra++;
      end
      check({tag, " no_second_op"}, 64'(extra), 64'd0);
      check({tag, " result_held"}, result, exp);
    end
  endtask

  initial begin
    int dones;
    logic [2:0] op;
    logic [31:0] a, b;
    int r;

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("MUL 7x-3",        3'd0, 32'd7,        32'hFFFF_FFFD, 0);
    do_op("MULH min x min",  3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    do_op("MULHU max x max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("MULHSU -1 x 2",   3'd2, 32'hFFFF_FFFF, 32'd2,        0);
    do_op("DIV overflow",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("REM overflow",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("DIVU 5/0",        3'd5, 32'd5,        32'd0,        0);
    do_op("REM 7/0",         3'd6, 32'd7,        32'd0,        0);
    do_op("DIV -7/2",        3'd4, 32'hFFFF_FFF9, 32'd2,        0);
    do_op("REM -7/2",        3'd6, 32'hFFFF_FFF9, 32'd2,        0);
    do_op("DIVU restart@10", 3'd5, 32'd1000,     32'd7,        10);
    do_op("REMU start@done", 3'd7, 32'd1000,     32'd7,        -1);

    // Reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; rs1_data = 32'd5; rs2_data = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset busy", busy, 1'b0);
    check("midreset result", result, 32'h0);
    check("midreset done", done, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    check("midreset no_done", 64'(dones), 64'd0);
    do_op("MUL 3x4 after reset", 3'd0, 32'd3, 32'd4, 0);

    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      r  = $urandom_range(0, 5);
      if (r == 0) b = 32'd0;
      else if (r == 1) b = $urandom_range(1, 5);
      else if (r == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      do_op($sformatf("rand%0d op%0d", i, op), op, a, b, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
